// File: rtl/fifo_access_ctrl.sv
// Arbitrating front end for a single-port 8x32 FIFO buffer: round-robin producers,
// one consumer, flush, and an authoritative occupancy count kept on this side.
module fifo_access_ctrl #(
  parameter int NUM_WR = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 8,
  parameter int CW     = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_gnt,
  input  logic                 rd_req,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [DW-1:0]        rd_data,
  input  logic                 flush,
  output logic                 fifo_en,
  output logic                 fifo_wr,
  output logic                 fifo_rd,
  output logic                 fifo_rst,
  output logic [DW-1:0]        fifo_din,
  input  logic [DW-1:0]        fifo_dout,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;

  logic [NUM_WR-1:0] wr_gnt_reg, wr_gnt_next;
  logic              rd_gnt_reg, rd_gnt_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              fifo_en_reg, fifo_en_next;
  logic              fifo_wr_reg, fifo_wr_next;
  logic              fifo_rd_reg, fifo_rd_next;
  logic              fifo_rst_reg, fifo_rst_next;
  logic [DW-1:0]     fifo_din_reg, fifo_din_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [PW-1:0]     rr_ptr_reg, rr_ptr_next;
  op_e               last_op_reg, last_op_next;

  logic              full_int, empty_int;
  logic [NUM_WR-1:0] wr_elig;
  logic              rd_elig;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              do_wr, do_rd;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_WR) s = s - NUM_WR;
    return PW'(s);
  endfunction

  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);

  // A port granted this cycle is masked so its held request is not counted twice.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_elig
      assign wr_elig[gi] = wr_req[gi] & ~wr_gnt_reg[gi] & ~full_int;
    end
  endgenerate

  assign rd_elig = rd_req & ~rd_gnt_reg & ~empty_int;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (!win_found && wr_elig[wrap_add(rr_ptr_reg, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_reg, k);
      end
    end
  end

  // When both sides compete, alternate against the last issued operation.
  assign do_wr = win_found & (~rd_elig | (last_op_reg == OP_READ));
  assign do_rd = rd_elig & ~do_wr;

  always_comb begin
    wr_gnt_next   = '0;
    rd_gnt_next   = 1'b0;
    rd_valid_next = rd_gnt_reg;
    fifo_en_next  = 1'b0;
    fifo_wr_next  = 1'b0;
    fifo_rd_next  = 1'b0;
    fifo_rst_next = 1'b0;
    fifo_din_next = fifo_din_reg;
    count_next    = count_reg;
    rr_ptr_next   = rr_ptr_reg;
    last_op_next  = last_op_reg;
    if (flush) begin
      fifo_rst_next = 1'b1;
      fifo_en_next  = 1'b1;
      count_next    = '0;
    end else if (do_wr) begin
      fifo_wr_next         = 1'b1;
      fifo_en_next         = 1'b1;
      fifo_din_next        = wr_data[int'(win_idx)*DW +: DW];
      wr_gnt_next[win_idx] = 1'b1;
      rr_ptr_next          = wrap_add(win_idx, 1);
      count_next           = count_reg + CW'(1);
      last_op_next         = OP_WRITE;
    end else if (do_rd) begin
      fifo_rd_next = 1'b1;
      fifo_en_next = 1'b1;
      rd_gnt_next  = 1'b1;
      count_next   = count_reg - CW'(1);
      last_op_next = OP_READ;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_gnt_reg   <= '0;
      rd_gnt_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      fifo_en_reg  <= 1'b0;
      fifo_wr_reg  <= 1'b0;
      fifo_rd_reg  <= 1'b0;
      fifo_rst_reg <= 1'b0;
      fifo_din_reg <= '0;
      count_reg    <= '0;
      rr_ptr_reg   <= '0;
      last_op_reg  <= OP_READ;
    end else begin
      wr_gnt_reg   <= wr_gnt_next;
      rd_gnt_reg   <= rd_gnt_next;
      rd_valid_reg <= rd_valid_next;
      fifo_en_reg  <= fifo_en_next;
      fifo_wr_reg  <= fifo_wr_next;
      fifo_rd_reg  <= fifo_rd_next;
      fifo_rst_reg <= fifo_rst_next;
      fifo_din_reg <= fifo_din_next;
      count_reg    <= count_next;
      rr_ptr_reg   <= rr_ptr_next;
      last_op_reg  <= last_op_next;
    end
  end

  assign wr_gnt   = wr_gnt_reg;
  assign rd_gnt   = rd_gnt_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = fifo_dout;
  assign fifo_en  = fifo_en_reg;
  assign fifo_wr  = fifo_wr_reg;
  assign fifo_rd  = fifo_rd_reg;
  assign fifo_rst = fifo_rst_reg;
  assign fifo_din = fifo_din_reg;
  assign count    = count_reg;
  assign full     = full_int;
  assign empty    = empty_int;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural buffer, cycle-level rule model, and a
// read-data scoreboard drained by an independent rd_valid monitor.
module tb_fifo_access_ctrl;
  localparam int NUM_WR = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic [NUM_WR-1:0]    wr_req;
  logic [NUM_WR*DW-1:0] wr_data;
  logic [NUM_WR-1:0]    wr_gnt;
  logic                 rd_req, rd_gnt, rd_valid;
  logic [DW-1:0]        rd_data;
  logic                 flush;
  logic                 fifo_en, fifo_wr, fifo_rd, fifo_rst;
  logic [DW-1:0]        fifo_din;
  logic [DW-1:0]        fifo_dout = '0;
  logic [CW-1:0]        count;
  logic                 full, empty;

  always #5 Clk = ~Clk;

  fifo_access_ctrl #(.NUM_WR(NUM_WR), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .flush(flush), .fifo_en(fifo_en), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_rst(fifo_rst), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
    .count(count), .full(full), .empty(empty)
  );

  // Behavioural single-port buffer driven by the controller's pins.
  logic [DW-1:0] bmem [DEPTH];
  logic [2:0]    bwp = '0, brp = '0;
  always @(posedge Clk) begin
    if (Rst || fifo_rst) begin
      bwp <= '0;
      brp <= '0;
    end else if (fifo_wr) begin
      bmem[bwp] <= fifo_din;
      bwp <= bwp + 3'd1;
    end else if (fifo_rd) begin
      fifo_dout <= bmem[brp];
      brp <= brp + 3'd1;
    end
  end

  int vectors = 0, miscompares = 0, cyc = 0, seq = 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: op 0 idle, 1 write, 2 read, 3 flush.
  int                m_count = 0, m_rr = 0, m_op = 0;
  bit                m_last_wr = 0, m_rgnt = 0, m_rv = 0;
  logic [NUM_WR-1:0] m_wgnt = '0;
  logic [DW-1:0]     m_din = '0;
  logic [DW-1:0]     content[$];
  logic [DW-1:0]     exp_rd[$];

  task automatic model_step();
    int  widx;
    bit  relig, rv_new;
    rv_new = Rst ? 1'b0 : m_rgnt;
    if (Rst) begin
      m_count = 0; m_rr = 0; m_last_wr = 0; m_wgnt = '0; m_rgnt = 0; m_op = 0; m_din = '0;
      content.delete();
      exp_rd.delete();
    end else if (flush) begin
      m_op = 3; m_count = 0; m_wgnt = '0; m_rgnt = 0;
      content.delete();
    end else begin
      widx = -1;
      for (int k = 0; k < NUM_WR; k++) begin
        int p = (m_rr + k) % NUM_WR;
        if (widx < 0 && wr_req[p] && !m_wgnt[p] && m_count < DEPTH) widx = p;
      end
      relig = rd_req && !m_rgnt && m_count > 0;
      m_wgnt = '0; m_rgnt = 0; m_op = 0;
      if (widx >= 0 && (!relig || !m_last_wr)) begin
        m_wgnt[widx] = 1'b1;
        m_din = wr_data[widx*DW +: DW];
        content.push_back(m_din);
        m_rr = (widx + 1) % NUM_WR;
        m_count++;
        m_last_wr = 1; m_op = 1;
      end else if (relig) begin
        m_rgnt = 1;
        exp_rd.push_back(content.pop_front());
        m_count--;
        m_last_wr = 0; m_op = 2;
      end
    end
    m_rv = rv_new;
  endtask

  task automatic check_outputs();
    cmp("wr_gnt",   32'(wr_gnt),   32'(m_wgnt));
    cmp("rd_gnt",   32'(rd_gnt),   32'(m_rgnt));
    cmp("rd_valid", 32'(rd_valid), 32'(m_rv));
    cmp("fifo_wr",  32'(fifo_wr),  32'(m_op == 1));
    cmp("fifo_rd",  32'(fifo_rd),  32'(m_op == 2));
    cmp("fifo_rst", 32'(fifo_rst), 32'(m_op == 3));
    cmp("fifo_en",  32'(fifo_en),  32'(m_op != 0));
    cmp("count",    32'(count),    32'(m_count));
    cmp("full",     32'(full),     32'(m_count == DEPTH));
    cmp("empty",    32'(empty),    32'(m_count == 0));
    cmp("fifo_din", fifo_din,      m_din);
  endtask

  // Independent monitor: every rd_valid must match the oldest outstanding read.
  logic [DW-1:0] mon_exp;
  always @(negedge Clk) begin
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_valid_unexpected cycle %0d: got rd_data %h expected no read", cyc, rd_data);
      end else begin
        mon_exp = exp_rd.pop_front();
        cmp("rd_data", rd_data, mon_exp);
      end
    end
  end

  // Producers hold each request until granted; probabilities are percent, reset is per mille.
  task automatic next_inputs(input logic [NUM_WR-1:0] wm, input int wp, input int rp,
                             input int fp, input int sp);
    Rst   = ($urandom_range(999) < sp);
    flush = !flush && ($urandom_range(99) < fp);
    for (int i = 0; i < NUM_WR; i++) begin
      if (!wr_req[i] || m_wgnt[i]) begin
        wr_req[i] = wm[i] && ($urandom_range(99) < wp);
        if (wr_req[i]) begin
          wr_data[i*DW +: DW] = 32'hA5A5_0000 + 32'(seq);
          seq++;
        end
      end
    end
    if (!rd_req || m_rgnt) rd_req = ($urandom_range(99) < rp);
  endtask

  task automatic run(input int n, input logic [NUM_WR-1:0] wm, input int wp, input int rp,
                     input int fp, input int sp);
    repeat (n) begin
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      cyc++;
      check_outputs();
      next_inputs(wm, wp, rp, fp, sp);
    end
  endtask

  initial begin
    Rst = 1'b1; flush = 1'b0; wr_req = '0; wr_data = '0; rd_req = 1'b0;
    run(2, 4'b0000, 0, 0, 0, 1000);
    run(5, 4'b0001, 100, 0, 0, 0);          // single writer, first word 0xA5A5_0001
    run(2, 4'b0000, 0, 0, 0, 1000);
    run(12, 4'b1111, 100, 0, 0, 0);         // round-robin fill to full
    run(20, 4'b1111, 100, 100, 0, 0);       // alternate at full
    flush = 1'b1;
    run(1, 4'b0000, 0, 0, 0, 0);
    run(6, 4'b0001, 100, 0, 0, 0);          // three words, then over-read
    run(12, 4'b0000, 0, 100, 0, 0);
    for (int k = 0; k < 40 && m_count < 5; k++) run(1, 4'b1111, 100, 0, 0, 0);
    rd_req = 1'b1; flush = 1'b1;            // flush with writer and reader active
    run(6, 4'b1111, 100, 100, 0, 0);
    for (int k = 0; k < 40 && !m_rgnt; k++) run(1, 4'b1111, 60, 100, 0, 0);
    Rst = 1'b1;                             // reset right behind a read grant
    run(1, 4'b1111, 100, 100, 0, 0);
    run(1500, 4'b1111, 60, 50, 3, 4);
    run(500, 4'b1010, 80, 30, 2, 2);
    run(6, 4'b0000, 0, 0, 0, 0);
    cmp("rd_leftover", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
